cam_capture: RTL and testbench

Parametrised camera capture front end. Runs in the camera pixel-clock domain, frames the vsync/href/byte stream from one sensor, and assembles 1- or 2-byte pixels. Emits each pixel with its (x, y) coordinate, optionally decimated by a power of two. Detects malformed lines and frames, counts frames, and feeds the per-camera reprojection stage.

---
 rtl/cam_capture_if.sv | 37 +++
 rtl/cam_capture.sv | 213 +++++++++++++++++++++
 tb/tb_cam_capture.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_capture_if.sv
// Sensor-side bundle for one camera capture front end.
// Carries the raw sensor stream (vsync, href, data) and everything the capture block produces:
//   vsync, href, data   : sensor framing and byte stream, synchronous to pclk
//   x, y, pixel         : decimated coordinate and assembled pixel, valid with pixel_valid
//   pixel_valid         : one-cycle pixel strobe
//   frame_start/done    : one-cycle frame boundary strobes
//   line_err/frame_err  : one-cycle malformed line / frame strobes
//   frame_count         : completed frame counter, wraps at 256
// modport master : the sensor / consumer side; modport slave : the capture block.
interface cam_capture_if #(
  parameter int unsigned BPP = 2,
  parameter int unsigned X_W = 10,
  parameter int unsigned Y_W = 9
);
  logic               vsync;
  logic               href;
  logic [7:0]         data;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [8*BPP-1:0]   pixel;
  logic               pixel_valid;
  logic               frame_start;
  logic               frame_done;
  logic               line_err;
  logic               frame_err;
  logic [7:0]         frame_count;

  modport master (
    output vsync, href, data,
    input  x, y, pixel, pixel_valid, frame_start, frame_done, line_err, frame_err, frame_count
  );

  modport slave (
    input  vsync, href, data,
    output x, y, pixel, pixel_valid, frame_start, frame_done, line_err, frame_err, frame_count
  );
endinterface

// File: rtl/cam_capture.sv
// Camera capture front end, pclk domain only.
// Frames the vsync/href/byte stream, assembles 1- or 2-byte pixels, tags them with a decimated
// (x, y) coordinate and flags malformed lines and frames.
//   pclk  : pixel clock
//   rst_n : asynchronous active-low reset
//   bus   : cam_capture_if slave port (sensor inputs, pixel/strobe/counter outputs)
module cam_capture #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned BPP       = 2,
  parameter int unsigned DEC_SHIFT = 0,
  parameter int unsigned X_W       = $clog2(H_ACTIVE),
  parameter int unsigned Y_W       = $clog2(V_ACTIVE)
) (
  input logic          pclk,
  input logic          rst_n,
  cam_capture_if.slave bus
);

  // Raw counters carry one extra bit so that a count equal to (or above) H_ACTIVE / V_ACTIVE
  // stays distinguishable even when the active size is a power of two.
  localparam int unsigned CX_W = X_W + 1;
  localparam int unsigned CY_W = Y_W + 1;
  localparam int unsigned PW   = 8 * BPP;

  localparam logic [CX_W-1:0] H_PIX   = CX_W'(H_ACTIVE);
  localparam logic [CY_W-1:0] V_PIX   = CY_W'(V_ACTIVE);
  localparam logic [CY_W:0]   V_LINES = (CY_W + 1)'(V_ACTIVE);
  localparam logic [CX_W-1:0] X_MASK  = CX_W'((1 << DEC_SHIFT) - 1);
  localparam logic [CY_W-1:0] Y_MASK  = CY_W'((1 << DEC_SHIFT) - 1);

  typedef enum logic [1:0] {StSync, StVblank, StActive} state_e;

  // Input stage and edge-detect copies
  logic       vs_q, vs_q2, hr_q, hr_q2;
  logic [7:0] data_q;

  state_e          state_q, state_d;
  logic            phase_q, phase_d;
  logic [7:0]      hold_q, hold_d;
  logic [CX_W-1:0] cx_q, cx_d;
  logic [CY_W-1:0] cy_q, cy_d;
  logic            line_open_q, line_open_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic [PW-1:0]   pixel_q, pixel_d;
  logic            pixel_valid_q, pixel_valid_d;
  logic            frame_start_q, frame_start_d;
  logic            frame_done_q, frame_done_d;
  logic            line_err_q, line_err_d;
  logic            frame_err_q, frame_err_d;
  logic [7:0]      count_q, count_d;

  logic            vs_rise, vs_fall, hr_rise;
  logic            byte_ok, line_close, phase_eff, px_done, keep, half_pending;
  logic [CX_W-1:0] cx_inc;
  logic [CY_W-1:0] cy_inc;
  logic [CY_W:0]   lines_seen;
  logic [PW-1:0]   pix_full;

  assign vs_rise      = vs_q & ~vs_q2;
  assign vs_fall      = ~vs_q & vs_q2;
  assign hr_rise      = hr_q & ~hr_q2;
  // href is only meaningful while vsync is low
  assign byte_ok      = hr_q & ~vs_q;
  // An open line closes on href fall, or when vsync rises underneath it
  assign line_close   = line_open_q & (~hr_q | vs_q);
  assign phase_eff    = phase_q & ~hr_rise;
  assign px_done      = byte_ok & ((BPP == 1) | phase_eff);
  assign half_pending = (BPP == 2) & phase_q;
  assign cx_inc       = (&cx_q) ? cx_q : cx_q + 1'b1;
  assign cy_inc       = (&cy_q) ? cy_q : cy_q + 1'b1;
  assign keep         = (cx_q < H_PIX) & (cy_q < V_PIX) &
                        ((cx_q & X_MASK) == '0) & ((cy_q & Y_MASK) == '0);
  assign lines_seen   = {1'b0, cy_q} + {{CY_W{1'b0}}, line_close};

  if (BPP == 2) begin : g_two_byte
    assign pix_full = {hold_q, data_q};
  end else begin : g_one_byte
    assign pix_full = data_q;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q   <= 1'b0;
      vs_q2  <= 1'b0;
      hr_q   <= 1'b0;
      hr_q2  <= 1'b0;
      data_q <= 8'h00;
    end else begin
      vs_q   <= bus.vsync;
      vs_q2  <= vs_q;
      hr_q   <= bus.href;
      hr_q2  <= hr_q;
      data_q <= bus.data;
    end
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    hold_d        = hold_q;
    cx_d          = cx_q;
    cy_d          = cy_q;
    line_open_d   = line_open_q;
    x_d           = x_q;
    y_d           = y_q;
    pixel_d       = pixel_q;
    count_d       = count_q;
    pixel_valid_d = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    line_err_d    = 1'b0;
    frame_err_d   = 1'b0;

    unique case (state_q)
      StSync: begin
        if (vs_rise) state_d = StVblank;
      end
      StVblank: begin
        if (vs_fall) begin
          state_d       = StActive;
          frame_start_d = 1'b1;
          cx_d          = '0;
          cy_d          = '0;
          phase_d       = 1'b0;
          line_open_d   = 1'b0;
        end
      end
      StActive: begin
        if (byte_ok) begin
          line_open_d = 1'b1;
          phase_d     = ~phase_eff;
          if (!phase_eff) hold_d = data_q;
          if (px_done) begin
            cx_d          = cx_inc;
            pixel_valid_d = keep;
            if (keep) begin
              x_d     = X_W'(cx_q >> DEC_SHIFT);
              y_d     = Y_W'(cy_q >> DEC_SHIFT);
              pixel_d = pix_full;
            end
          end
        end
        if (line_close) begin
          line_err_d  = (cx_q != H_PIX) | half_pending;
          cx_d        = '0;
          cy_d        = cy_inc;
          phase_d     = 1'b0;
          line_open_d = 1'b0;
        end
        if (vs_rise) begin
          state_d      = StVblank;
          frame_done_d = 1'b1;
          count_d      = count_q + 8'd1;
          frame_err_d  = (lines_seen != V_LINES);
          cx_d         = '0;
          cy_d         = '0;
          phase_d      = 1'b0;
          line_open_d  = 1'b0;
        end
      end
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StSync;
      phase_q       <= 1'b0;
      hold_q        <= 8'h00;
      cx_q          <= '0;
      cy_q          <= '0;
      line_open_q   <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      count_q       <= 8'h00;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      hold_q        <= hold_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      line_open_q   <= line_open_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      line_err_q    <= line_err_d;
      frame_err_q   <= frame_err_d;
      count_q       <= count_d;
    end
  end

  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.pixel       = pixel_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.line_err    = line_err_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.frame_count = count_q;

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture: two instances share one sensor stream.
//   dut_a : H=4, V=3, 2 bytes/pixel, no decimation
//   dut_b : H=4, V=4, 1 byte/pixel, decimation by 2
// The reference model derives expected pixels, coordinates and strobe counts from the byte
// stream with plain arithmetic (pixel index = byte index / BPP, etc.).
module tb_cam_capture;
  localparam int unsigned H   = 4;
  localparam int unsigned VA  = 3;
  localparam int unsigned BA  = 2;
  localparam int unsigned DA  = 0;
  localparam int unsigned VB  = 4;
  localparam int unsigned BB  = 1;
  localparam int unsigned DB  = 1;
  localparam int unsigned XW  = $clog2(H);
  localparam int unsigned YWA = $clog2(VA);
  localparam int unsigned YWB = $clog2(VB);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vsync, href;
  logic [7:0] data;

  always #5 clk = ~clk;

  cam_capture_if #(.BPP(BA), .X_W(XW), .Y_W(YWA)) if_a ();
  cam_capture_if #(.BPP(BB), .X_W(XW), .Y_W(YWB)) if_b ();

  assign if_a.vsync = vsync;
  assign if_a.href  = href;
  assign if_a.data  = data;
  assign if_b.vsync = vsync;
  assign if_b.href  = href;
  assign if_b.data  = data;

  cam_capture #(
    .H_ACTIVE(H), .V_ACTIVE(VA), .BPP(BA), .DEC_SHIFT(DA), .X_W(XW), .Y_W(YWA)
  ) dut_a (
    .pclk  (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  cam_capture #(
    .H_ACTIVE(H), .V_ACTIVE(VB), .BPP(BB), .DEC_SHIFT(DB), .X_W(XW), .Y_W(YWB)
  ) dut_b (
    .pclk  (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  typedef struct {
    int cyc;
    int x;
    int y;
    int pix;
  } exp_t;

  int   bpp_c [2];
  int   v_c   [2];
  int   ds_c  [2];
  exp_t qa[$];
  exp_t qb[$];
  int   exp_le [2];
  int   exp_fe [2];
  int   exp_fs, exp_fd, exp_cnt;
  int   act_le [2];
  int   act_fe [2];
  int   act_fs [2];
  int   act_fd [2];
  bit   armed, in_frame;
  int   line_idx;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    for (int c = 0; c < 2; c++) begin
      exp_le[c] = 0; exp_fe[c] = 0;
      act_le[c] = 0; act_fe[c] = 0; act_fs[c] = 0; act_fd[c] = 0;
    end
    exp_fs = 0; exp_fd = 0; exp_cnt = 0;
    armed = 1'b0; in_frame = 1'b0; line_idx = 0;
  endtask

  // Vsync rise: closes an active frame; ends with a stray href pulse that must be ignored.
  task automatic vs_rise_t();
    @(negedge clk);
    vsync = 1'b1;
    data  = 8'($urandom);
    if (in_frame) begin
      exp_fd++;
      exp_cnt++;
      for (int c = 0; c < 2; c++) if (line_idx != v_c[c]) exp_fe[c]++;
      in_frame = 1'b0;
    end
    armed = 1'b1;
    @(negedge clk);
    @(negedge clk); href = 1'b0;
    @(negedge clk); href = 1'b1; data = 8'($urandom);
    @(negedge clk); href = 1'b0;
    @(negedge clk);
  endtask

  task automatic vs_fall_t();
    @(negedge clk);
    vsync = 1'b0;
    href  = 1'b0;
    if (armed) begin
      in_frame = 1'b1;
      exp_fs++;
      line_idx = 0;
    end
    repeat (3) @(negedge clk);
  endtask

  // One line of len bytes; seq >= 0 gives bytes seq, seq+1, ..., otherwise random bytes.
  // vs_close raises vsync while href is still high instead of ending the line normally.
  task automatic send_line(input int len, input int seq, input bit vs_close);
    int   bytes [16];
    int   bpp, d, k, pix;
    exp_t e;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      bytes[i] = (seq >= 0) ? ((seq + i) & 8'hff) : int'($urandom_range(0, 255));
      href     = 1'b1;
      data     = 8'(bytes[i]);
      if (in_frame) begin
        for (int c = 0; c < 2; c++) begin
          bpp = bpp_c[c];
          d   = 1 << ds_c[c];
          k   = i / bpp;
          if ((i % bpp) == bpp - 1 && k < int'(H) && line_idx < v_c[c] &&
              (k % d) == 0 && (line_idx % d) == 0) begin
            pix   = (bpp == 2) ? bytes[i-1] * 256 + bytes[i] : bytes[i];
            e.cyc = cyc + 2;
            e.x   = k / d;
            e.y   = line_idx / d;
            e.pix = pix;
            if (c == 0) qa.push_back(e);
            else qb.push_back(e);
          end
        end
      end
    end
    if (in_frame) begin
      for (int c = 0; c < 2; c++)
        if ((len % bpp_c[c]) != 0 || (len / bpp_c[c]) != int'(H)) exp_le[c]++;
      line_idx++;
    end
    if (vs_close) begin
      vs_rise_t();
    end else begin
      @(negedge clk);
      href = 1'b0;
      data = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic check_frame();
    check("a_line_err_count", act_le[0], exp_le[0]);
    check("b_line_err_count", act_le[1], exp_le[1]);
    check("a_frame_err_count", act_fe[0], exp_fe[0]);
    check("b_frame_err_count", act_fe[1], exp_fe[1]);
    check("a_frame_start_count", act_fs[0], exp_fs);
    check("b_frame_start_count", act_fs[1], exp_fs);
    check("a_frame_done_count", act_fd[0], exp_fd);
    check("b_frame_done_count", act_fd[1], exp_fd);
    check("a_frame_count", 32'(if_a.frame_count), exp_cnt % 256);
    check("b_frame_count", 32'(if_b.frame_count), exp_cnt % 256);
    check("a_pixels_missing", qa.size(), 0);
    check("b_pixels_missing", qb.size(), 0);
  endtask

  task automatic end_frame();
    vs_rise_t();
    vs_fall_t();
    check_frame();
  endtask

  task automatic check_all_zero();
    check("rst_a_x", 32'(if_a.x), 0);
    check("rst_a_y", 32'(if_a.y), 0);
    check("rst_a_pixel", 32'(if_a.pixel), 0);
    check("rst_a_strobes", {27'd0, if_a.pixel_valid, if_a.frame_start, if_a.frame_done,
                            if_a.line_err, if_a.frame_err}, 0);
    check("rst_a_frame_count", 32'(if_a.frame_count), 0);
    check("rst_b_x", 32'(if_b.x), 0);
    check("rst_b_y", 32'(if_b.y), 0);
    check("rst_b_pixel", 32'(if_b.pixel), 0);
    check("rst_b_strobes", {27'd0, if_b.pixel_valid, if_b.frame_start, if_b.frame_done,
                            if_b.line_err, if_b.frame_err}, 0);
    check("rst_b_frame_count", 32'(if_b.frame_count), 0);
  endtask

  // Output monitors, sampled 1 ns after the active edge
  initial begin : mon_a
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (if_a.pixel_valid) begin
        check("a_pixel_expected", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0) begin
          e = qa.pop_front();
          check("a_pixel_cycle", cyc, e.cyc);
          check("a_pixel_x", 32'(if_a.x), e.x);
          check("a_pixel_y", 32'(if_a.y), e.y);
          check("a_pixel_value", 32'(if_a.pixel), e.pix);
        end
      end
      if (if_a.line_err)    act_le[0]++;
      if (if_a.frame_err)   act_fe[0]++;
      if (if_a.frame_start) act_fs[0]++;
      if (if_a.frame_done)  act_fd[0]++;
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (if_b.pixel_valid) begin
        check("b_pixel_expected", 32'(qb.size() != 0), 32'd1);
        if (qb.size() != 0) begin
          e = qb.pop_front();
          check("b_pixel_cycle", cyc, e.cyc);
          check("b_pixel_x", 32'(if_b.x), e.x);
          check("b_pixel_y", 32'(if_b.y), e.y);
          check("b_pixel_value", 32'(if_b.pixel), e.pix);
        end
      end
      if (if_b.line_err)    act_le[1]++;
      if (if_b.frame_err)   act_fe[1]++;
      if (if_b.frame_start) act_fs[1]++;
      if (if_b.frame_done)  act_fd[1]++;
    end
  end

  initial begin : stim
    int nl, len, r;
    bpp_c[0] = BA; bpp_c[1] = BB;
    v_c[0]   = VA; v_c[1]   = VB;
    ds_c[0]  = DA; ds_c[1]  = DB;
    vsync = 1'b0; href = 1'b0; data = 8'h00;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero();
    rst_n = 1'b1;

    // Lines before the first vsync must be ignored
    send_line(8, 100, 1'b0);
    vs_rise_t();
    vs_fall_t();
    check_frame();

    // Clean frame for dut_a: bytes 0x01..0x18
    send_line(8, 8'h01, 1'b0);
    send_line(8, 8'h09, 1'b0);
    send_line(8, 8'h11, 1'b0);
    end_frame();
    check("clean_a_line_err", act_le[0], 0);
    check("clean_a_frame_err", act_fe[0], 0);

    // Long middle line (5 pixels for dut_a)
    send_line(8, 8'h20, 1'b0);
    send_line(10, 8'h30, 1'b0);
    send_line(8, 8'h40, 1'b0);
    end_frame();

    // Odd byte count: next line must restart byte pairing
    send_line(9, 8'h50, 1'b0);
    send_line(8, 8'h60, 1'b0);
    send_line(8, 8'h70, 1'b0);
    end_frame();

    // Clean 4x4 frame for dut_b
    for (int l = 0; l < 4; l++) send_line(4, 8'h80 + 16 * l, 1'b0);
    end_frame();

    // vsync rises while href is still high
    send_line(8, -1, 1'b0);
    send_line(8, -1, 1'b0);
    send_line(5, -1, 1'b1);
    vs_fall_t();
    check_frame();

    // Randomized frames
    for (int f = 0; f < 20; f++) begin
      nl = $urandom_range(1, 5);
      for (int l = 0; l < nl; l++) begin
        r   = $urandom_range(0, 3);
        len = (r == 0) ? 8 : (r == 1) ? 4 : int'($urandom_range(1, 11));
        if (l == nl - 1 && $urandom_range(0, 3) == 0) begin
          send_line(len, -1, 1'b1);
          vs_fall_t();
          check_frame();
        end else begin
          send_line(len, -1, 1'b0);
          if (l == nl - 1) end_frame();
        end
      end
    end

    // Reset in the middle of a line, released mid-frame
    send_line(8, -1, 1'b0);
    @(negedge clk); href = 1'b1; data = 8'($urandom);
    @(negedge clk); data = 8'($urandom);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero();
    model_reset();
    @(negedge clk); data = 8'($urandom);
    @(negedge clk); data = 8'($urandom);
    rst_n = 1'b1;
    @(negedge clk); data = 8'($urandom);
    send_line(6, -1, 1'b0);
    send_line(8, -1, 1'b0);
    check_frame();
    check("no_start_after_reset", act_fs[0], 0);
    vs_rise_t();
    vs_fall_t();
    check_frame();

    // Two-line frame: short frame error on both instances
    send_line(8, -1, 1'b0);
    send_line(4, -1, 1'b0);
    end_frame();
    check("short_frame_a_err", act_fe[0], 1);
    check("short_frame_b_err", act_fe[1], 1);

    // Run up to the 256th frame_done since reset
    for (int f = 0; f < 255; f++) begin
      send_line(int'($urandom_range(1, 9)), -1, 1'b0);
      end_frame();
    end
    check("wrap_a_frame_count", 32'(if_a.frame_count), 0);
    check("wrap_b_frame_count", 32'(if_b.frame_count), 0);
    check("wrap_a_frame_done", act_fd[0], 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
